// File: rtl/h6_mul_sequencer_pkg.sv
// h6_mul_sequencer_pkg: state encoding, strobe bundle and decode helper for the H6 MUL sequencer
package h6_mul_sequencer_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_CLRH, S_LOAD, S_P2, S_P3, S_P4, S_WB_HI, S_WB_LO, S_DONE
  } state_e;
  localparam logic [2:0] ILLEGAL_DST = 3'd5;
  localparam int DEC_W = 8;
  typedef struct packed {
    logic busy;
    logic done;
    logic b0b;
    logic mul1;
    logic mul2_1;
    logic mul2_2;
    logic rst_h6;
    logic inqlk;
    logic intwo;
    logic inthree;
    logic infour;
    logic als_a;
    logic als_q;
    logic mul3;
  } ctl_t;
  // Moore strobe pattern for each state; the A-bus source is enabled exactly when B0B is
  function automatic ctl_t ctl_of(state_e s);
    ctl_t c;
    c = '0;
    c.busy    = s != S_IDLE;
    c.done    = s == S_DONE;
    c.rst_h6  = s == S_CLRH;
    c.b0b     = s == S_LOAD || s == S_P2;
    c.mul1    = s == S_LOAD;
    c.mul2_1  = s == S_LOAD;
    c.inqlk   = s == S_LOAD;
    c.mul2_2  = s == S_P2;
    c.intwo   = s == S_P2;
    c.inthree = s == S_P3;
    c.infour  = s == S_P4;
    c.als_a   = s == S_WB_HI;
    c.mul3    = s == S_WB_HI;
    c.als_q   = s == S_WB_LO;
    return c;
  endfunction
endpackage

// File: rtl/h6_mul_sequencer_onehot_dec3to8.sv
// onehot_dec3to8: enabled 3-to-8 one-hot decoder
module onehot_dec3to8
  import h6_mul_sequencer_pkg::*;
(
  input  logic             en_i,
  input  logic [2:0]       sel_i,
  output logic [DEC_W-1:0] dec_o
);
  assign dec_o = en_i ? DEC_W'(1) << sel_i : '0;
endmodule

// File: rtl/h6_mul_sequencer.sv
// h6_mul_sequencer: sequences the H6 shift-add multiplier and bus gates for one MUL instruction
module h6_mul_sequencer
  import h6_mul_sequencer_pkg::*;
#(
  parameter int STEPS = 16,
  parameter int CNT_W = 5
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       start,
  input  logic [2:0] a_sel,
  input  logic [2:0] hi_sel,
  input  logic [2:0] lo_sel,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] RA_en,
  output logic [7:0] SR_en,
  output logic       B0B,
  output logic       MUL1,
  output logic       MUL2_1,
  output logic       MUL2_2,
  output logic       Rst_H6,
  output logic       inQLK,
  output logic       inTWO,
  output logic       inTHREE,
  output logic       inFOUR,
  output logic       ALS_H6_a,
  output logic       ALS_H6_q,
  output logic       MUL3
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic err_q, err_d;
  ctl_t ctl_q, ctl_d;
  logic [DEC_W-1:0] ra_q, ra_d, sr_q, sr_d;
  logic accept, wb_hi_ok, wb_lo_ok;
  assign accept = state_q == S_IDLE && start && !abort;
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
      ctl_q   <= '0;
      ra_q    <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      ctl_q   <= ctl_d;
      ra_q    <= ra_d;
      sr_q    <= sr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = accept ? a_sel : a_q;
    hi_d    = accept ? hi_sel : hi_q;
    lo_d    = accept ? lo_sel : lo_q;
    case (state_q)
      S_IDLE:  state_d = accept ? S_CLRH : S_IDLE;
      S_CLRH:  state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_P2;
        cnt_d   = '0;
      end
      S_P2:    state_d = S_P3;
      S_P3:    state_d = S_P4;
      S_P4: begin
        state_d = cnt_q == LAST ? S_WB_HI : S_P2;
        cnt_d   = cnt_q + 1'b1;
      end
      S_WB_HI: state_d = S_WB_LO;
      S_WB_LO: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end
  // Outputs are computed from the next state so each registered strobe lines up with its state
  always_comb begin
    ctl_d    = ctl_of(state_d);
    wb_hi_ok = ctl_d.als_a && hi_d != ILLEGAL_DST;
    wb_lo_ok = ctl_d.als_q && lo_d != ILLEGAL_DST;
    err_d    = !accept && (err_q || (ctl_d.als_a && hi_d == ILLEGAL_DST)
                                 || (ctl_d.als_q && lo_d == ILLEGAL_DST));
  end
  onehot_dec3to8 u_ra_dec (
    .en_i  (ctl_d.b0b),
    .sel_i (a_d),
    .dec_o (ra_d)
  );
  onehot_dec3to8 u_sr_dec (
    .en_i  (wb_hi_ok || wb_lo_ok),
    .sel_i (ctl_d.als_a ? hi_d : lo_d),
    .dec_o (sr_d)
  );
  assign busy     = ctl_q.busy;
  assign done     = ctl_q.done;
  assign err      = err_q;
  assign RA_en    = ra_q;
  assign SR_en    = sr_q;
  assign B0B      = ctl_q.b0b;
  assign MUL1     = ctl_q.mul1;
  assign MUL2_1   = ctl_q.mul2_1;
  assign MUL2_2   = ctl_q.mul2_2;
  assign Rst_H6   = ctl_q.rst_h6;
  assign inQLK    = ctl_q.inqlk;
  assign inTWO    = ctl_q.intwo;
  assign inTHREE  = ctl_q.inthree;
  assign inFOUR   = ctl_q.infour;
  assign ALS_H6_a = ctl_q.als_a;
  assign ALS_H6_q = ctl_q.als_q;
  assign MUL3     = ctl_q.mul3;
endmodule
